// File: rtl/ipr_nvme_cq_sm_if.sv
// rtl/ipr_nvme_cq_sm_if.sv - CQ FIFO, parsed-completion, head-doorbell and status signals of ipr_nvme_cq_sm
interface ipr_nvme_cq_sm_if;
    logic        is_io_queue;
    logic [31:0] din;
    logic        cq_fifo_empty;
    logic        rd_en;
    logic        cqe_valid;
    logic        cqe_ack;
    logic [31:0] cqe_dw0;
    logic [15:0] cqe_sq_head;
    logic [15:0] cqe_sq_id;
    logic [15:0] cqe_cid;
    logic [14:0] cqe_status;
    logic        cqe_is_io;
    logic [15:0] acq_head_local;
    logic [15:0] iocq_head_local;
    logic        acq_head_done;
    logic        acq_head_done_ack;
    logic        iocq_head_done;
    logic        iocq_head_done_ack;
    logic        phase_err;
    logic        cq_timeout;
    logic [15:0] admin_cpl_cnt;
    logic [31:0] io_cpl_cnt;

    modport master (
        input  is_io_queue, din, cq_fifo_empty, cqe_ack, acq_head_done_ack, iocq_head_done_ack,
        output rd_en, cqe_valid, cqe_dw0, cqe_sq_head, cqe_sq_id, cqe_cid, cqe_status, cqe_is_io,
               acq_head_local, iocq_head_local, acq_head_done, iocq_head_done, phase_err,
               cq_timeout, admin_cpl_cnt, io_cpl_cnt
    );

    modport slave (
        output is_io_queue, din, cq_fifo_empty, cqe_ack, acq_head_done_ack, iocq_head_done_ack,
        input  rd_en, cqe_valid, cqe_dw0, cqe_sq_head, cqe_sq_id, cqe_cid, cqe_status, cqe_is_io,
               acq_head_local, iocq_head_local, acq_head_done, iocq_head_done, phase_err,
               cq_timeout, admin_cpl_cnt, io_cpl_cnt
    );
endinterface

// File: rtl/ipr_nvme_cq_sm.sv
// rtl/ipr_nvme_cq_sm.sv - CQE parser: 4-dword pop, phase check, ACQ/IOCQ head tracking and head-doorbell handshake
// Optional starve timeout enabled by NVME_CQ_TIMEOUT_EN.
module ipr_nvme_cq_sm #(
`ifdef NVME_CQ_TIMEOUT_EN
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024,
`endif
    parameter logic [15:0] ADMIN_SIZE = 16'h000f,
    parameter logic [15:0] IO_SIZE    = 16'h003f
) (
    input  logic             clk_in,
    input  logic             resetb,
    ipr_nvme_cq_sm_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE    = 4'b0001,
        S_READ    = 4'b0010,
        S_CHECK   = 4'b0100,
        S_PRESENT = 4'b1000
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        is_io_q, is_io_d;
    logic [31:0] dw0_q, dw0_d, dw2_q, dw2_d, dw3_q, dw3_d;
    logic        ph_adm_q, ph_adm_d, ph_io_q, ph_io_d;
    logic [15:0] acq_head_q, acq_head_d, iocq_head_q, iocq_head_d;
    logic        acq_done_q, acq_done_d, iocq_done_q, iocq_done_d;
    logic [15:0] adm_cnt_q, adm_cnt_d;
    logic [31:0] io_cnt_q, io_cnt_d;
    logic        phase_err_c;
    logic        pop;
    logic        phase_ok;
`ifdef NVME_CQ_TIMEOUT_EN
    logic [15:0] starve_q, starve_d;
    logic        timeout_q, timeout_d;
`endif

    assign pop      = (state_q == S_READ) && !bus.cq_fifo_empty;
    assign phase_ok = dw3_q[16] == (is_io_q ? ph_io_q : ph_adm_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_io_d     = is_io_q;
        dw0_d       = dw0_q;
        dw2_d       = dw2_q;
        dw3_d       = dw3_q;
        ph_adm_d    = ph_adm_q;
        ph_io_d     = ph_io_q;
        acq_head_d  = acq_head_q;
        iocq_head_d = iocq_head_q;
        // an ack only clears; a set in S_CHECK below overrides it
        acq_done_d  = acq_done_q & ~bus.acq_head_done_ack;
        iocq_done_d = iocq_done_q & ~bus.iocq_head_done_ack;
        adm_cnt_d   = adm_cnt_q;
        io_cnt_d    = io_cnt_q;
        phase_err_c = 1'b0;
`ifdef NVME_CQ_TIMEOUT_EN
        starve_d    = '0;
        timeout_d   = timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!bus.cq_fifo_empty) state_d = S_READ;
            end
            S_READ: begin
                if (pop) begin
                    cnt_d = cnt_q + 2'd1;
                    case (cnt_q)
                        2'd0: begin
                            dw0_d   = bus.din;
                            is_io_d = bus.is_io_queue;
                        end
                        2'd2: dw2_d = bus.din;
                        2'd3: begin
                            dw3_d   = bus.din;
                            state_d = S_CHECK;
                        end
                        default: ;
                    endcase
                end
`ifdef NVME_CQ_TIMEOUT_EN
                else if (starve_q == TIMEOUT_CYCLES - 16'd1) begin
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                end else begin
                    starve_d = starve_q + 16'd1;
                end
`endif
            end
            S_CHECK: begin
                if (phase_ok) begin
                    if (is_io_q) begin
                        if (iocq_head_q == IO_SIZE) begin
                            iocq_head_d = '0;
                            ph_io_d     = ~ph_io_q;
                        end else begin
                            iocq_head_d = iocq_head_q + 16'd1;
                        end
                        iocq_done_d = 1'b1;
                    end else begin
                        if (acq_head_q == ADMIN_SIZE) begin
                            acq_head_d = '0;
                            ph_adm_d   = ~ph_adm_q;
                        end else begin
                            acq_head_d = acq_head_q + 16'd1;
                        end
                        acq_done_d = 1'b1;
                    end
                    state_d = S_PRESENT;
                end else begin
                    phase_err_c = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_PRESENT: begin
                if (bus.cqe_ack) begin
                    if (is_io_q) io_cnt_d = io_cnt_q + 32'd1;
                    else         adm_cnt_d = adm_cnt_q + 16'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (resetb) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            is_io_q     <= 1'b0;
            dw0_q       <= '0;
            dw2_q       <= '0;
            dw3_q       <= '0;
            ph_adm_q    <= 1'b1;
            ph_io_q     <= 1'b1;
            acq_head_q  <= '0;
            iocq_head_q <= '0;
            acq_done_q  <= 1'b0;
            iocq_done_q <= 1'b0;
            adm_cnt_q   <= '0;
            io_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_io_q     <= is_io_d;
            dw0_q       <= dw0_d;
            dw2_q       <= dw2_d;
            dw3_q       <= dw3_d;
            ph_adm_q    <= ph_adm_d;
            ph_io_q     <= ph_io_d;
            acq_head_q  <= acq_head_d;
            iocq_head_q <= iocq_head_d;
            acq_done_q  <= acq_done_d;
            iocq_done_q <= iocq_done_d;
            adm_cnt_q   <= adm_cnt_d;
            io_cnt_q    <= io_cnt_d;
        end
    end

`ifdef NVME_CQ_TIMEOUT_EN
    always_ff @(posedge clk_in) begin
        if (resetb) begin
            starve_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            starve_q  <= starve_d;
            timeout_q <= timeout_d;
        end
    end
    assign bus.cq_timeout = timeout_q;
`else
    assign bus.cq_timeout = 1'b0;
`endif

    assign bus.rd_en           = pop;
    assign bus.cqe_valid       = (state_q == S_PRESENT);
    assign bus.cqe_dw0         = dw0_q;
    assign bus.cqe_sq_head     = dw2_q[15:0];
    assign bus.cqe_sq_id       = dw2_q[31:16];
    assign bus.cqe_cid         = dw3_q[15:0];
    assign bus.cqe_status      = dw3_q[31:17];
    assign bus.cqe_is_io       = is_io_q;
    assign bus.acq_head_local  = acq_head_q;
    assign bus.iocq_head_local = iocq_head_q;
    assign bus.acq_head_done   = acq_done_q;
    assign bus.iocq_head_done  = iocq_done_q;
    assign bus.phase_err       = phase_err_c;
    assign bus.admin_cpl_cnt   = adm_cnt_q;
    assign bus.io_cpl_cnt      = io_cnt_q;
endmodule

// File: tb/tb_ipr_nvme_cq_sm.sv
// tb/tb_ipr_nvme_cq_sm.sv - randomized self-checking bench for ipr_nvme_cq_sm against a queue-level model
module tb_ipr_nvme_cq_sm;
`ifdef NVME_CQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    ipr_nvme_cq_sm_if bus();

    ipr_nvme_cq_sm dut (.clk_in(clk), .resetb(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int pops  = 0;
    logic [31:0] fifo_q[$];

    int          qsize[2] = '{16, 64};
    int          exp_head[2];
    bit          exp_ph[2];
    bit          exp_done[2];
    logic [15:0] exp_adm_cnt;
    logic [31:0] exp_io_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        bus.cq_fifo_empty = (fifo_q.size() == 0);
        bus.din = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    endtask

    task automatic push(input logic [31:0] d);
        fifo_q.push_back(d);
        drive_fifo();
    endtask

    task automatic tick();
        logic pop_now;
        #4;
        pop_now = bus.rd_en;
        @(posedge clk);
        #1;
        cyc++;
        if (pop_now === 1'b1 && fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
            pops++;
        end
        drive_fifo();
    endtask

    task automatic set_done_ack(input bit io, input logic v);
        if (io) bus.iocq_head_done_ack = v;
        else    bus.acq_head_done_ack  = v;
    endtask

    task automatic model_reset();
        exp_head    = '{0, 0};
        exp_ph      = '{1'b1, 1'b1};
        exp_done    = '{1'b0, 1'b0};
        exp_adm_cnt = '0;
        exp_io_cnt  = '0;
    endtask

    function automatic logic [31:0] mk_dw3(input bit ph);
        logic [31:0] r;
        r     = $urandom;
        r[16] = ph;
        return r;
    endfunction

    task automatic chk_queues(input string tag);
        chk({tag, "_acq_head"}, bus.acq_head_local, exp_head[0]);
        chk({tag, "_iocq_head"}, bus.iocq_head_local, exp_head[1]);
        chk({tag, "_acq_done"}, bus.acq_head_done, exp_done[0]);
        chk({tag, "_iocq_done"}, bus.iocq_head_done, exp_done[1]);
        chk({tag, "_adm_cnt"}, bus.admin_cpl_cnt, exp_adm_cnt);
        chk({tag, "_io_cnt"}, bus.io_cpl_cnt, exp_io_cnt);
    endtask

    task automatic ack_done(input bit io);
        set_done_ack(io, 1'b1);
        tick();
        set_done_ack(io, 1'b0);
        exp_done[io] = 1'b0;
        chk(io ? "iocq_done_clr" : "acq_done_clr", io ? bus.iocq_head_done : bus.acq_head_done, 0);
    endtask

    task automatic run_entry(input bit io, input logic [31:0] d0, input logic [31:0] d2,
                             input logic [31:0] d3, input int ack_delay, input bit do_push,
                             input bit ack_at_check);
        bit accept, seen, ack_on, ack_used;
        int p0, first_cyc, t, c, pb, fsz;
        logic [31:0] d1;
        accept = (d3[16] == exp_ph[io]);
        bus.is_io_queue = io;
        if (do_push) begin
            d1 = $urandom;
            push(d0); push(d1); push(d2); push(d3);
        end
        p0 = pops; first_cyc = -1; seen = 0; t = 0; ack_on = 0; ack_used = 0;
        while (!seen && t < 64) begin
            c = cyc; pb = pops;
            tick();
            t++;
            if (pops != pb && pb == p0) first_cyc = c;
            // the queue type is latched at the first dword; later changes must be ignored
            if (pops != p0) bus.is_io_queue = 1'($urandom_range(0, 1));
            if (ack_on) begin
                set_done_ack(io, 1'b0);
                ack_on = 0;
            end else if (ack_at_check && !ack_used && pops - p0 == 4) begin
                set_done_ack(io, 1'b1);
                ack_on = 1; ack_used = 1;
            end
            if (bus.cqe_valid === 1'b1 || bus.phase_err === 1'b1) seen = 1;
        end
        chk("entry_outcome_seen", seen, 1);
        if (accept) begin
            exp_head[io] = (exp_head[io] + 1) % qsize[io];
            if (exp_head[io] == 0) exp_ph[io] = ~exp_ph[io];
            exp_done[io] = 1'b1;
            chk("cqe_valid", bus.cqe_valid, 1);
            chk("no_phase_err", bus.phase_err, 0);
            if (do_push) chk("latency", cyc - first_cyc, 5);
            chk("dw0", bus.cqe_dw0, d0);
            chk("sq_head", bus.cqe_sq_head, d2[15:0]);
            chk("sq_id", bus.cqe_sq_id, d2[31:16]);
            chk("cid", bus.cqe_cid, d3[15:0]);
            chk("status", bus.cqe_status, d3[31:17]);
            chk("is_io", bus.cqe_is_io, io);
            chk_queues("accept");
            fsz = fifo_q.size();
            repeat (ack_delay) begin
                tick();
                chk("hold_valid", bus.cqe_valid, 1);
                chk("hold_dw0", bus.cqe_dw0, d0);
                chk("hold_cid", bus.cqe_cid, d3[15:0]);
                chk("hold_no_pop", fifo_q.size(), fsz);
            end
            bus.cqe_ack = 1'b1;
            tick();
            bus.cqe_ack = 1'b0;
            if (io) exp_io_cnt++;
            else    exp_adm_cnt++;
            chk("valid_drop", bus.cqe_valid, 0);
            chk_queues("after_ack");
        end else begin
            chk("phase_err", bus.phase_err, 1);
            chk("reject_valid", bus.cqe_valid, 0);
            chk_queues("reject");
            tick();
            chk("phase_err_pulse", bus.phase_err, 0);
        end
    endtask

    initial begin
        logic [31:0] a0, a2, a3, b0, b2, b3;
        bit io;
        bus.is_io_queue = 0;
        bus.cqe_ack = 0;
        bus.acq_head_done_ack = 0;
        bus.iocq_head_done_ack = 0;
        drive_fifo();
        model_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_valid", bus.cqe_valid, 0);
        chk("rst_rd_en", bus.rd_en, 0);
        chk("rst_phase_err", bus.phase_err, 0);
        chk("rst_timeout", bus.cq_timeout, 0);
        chk("rst_dw0", bus.cqe_dw0, 0);
        chk_queues("rst");

        // IOCQ entry with phase 0 right after reset is rejected
        run_entry(1, 32'h0, 32'h0, mk_dw3(1'b0), 0, 1, 0);
        chk("io_reject_head", bus.iocq_head_local, 0);
        chk("io_reject_cnt", bus.io_cpl_cnt, 0);

        run_entry(0, 32'h11, 32'h0000_0005, 32'h0001_0007, 0, 1, 0);
        chk("t1_cid", bus.cqe_cid, 7);
        chk("t1_sq_head", bus.cqe_sq_head, 5);
        chk("t1_status", bus.cqe_status, 0);
        chk("t1_acq_head", bus.acq_head_local, 1);
        chk("t1_acq_done", bus.acq_head_done, 1);
        chk("t1_adm_cnt", bus.admin_cpl_cnt, 1);

        // doorbell coalescing across completions, then ack
        run_entry(0, $urandom, $urandom, mk_dw3(1'b1), 1, 1, 0);
        run_entry(0, $urandom, $urandom, mk_dw3(1'b1), 0, 1, 0);
        chk("coal_done", bus.acq_head_done, 1);
        chk("coal_head", bus.acq_head_local, 3);
        ack_done(0);
        run_entry(0, $urandom, $urandom, mk_dw3(1'b1), 0, 1, 1);
        chk("ack_at_check_done", bus.acq_head_done, 1);

        // head wrap 15 -> 0 toggles the expected phase
        repeat (12) run_entry(0, $urandom, $urandom, mk_dw3(1'b1), 0, 1, 0);
        chk("wrap_head", bus.acq_head_local, 0);
        run_entry(0, $urandom, $urandom, mk_dw3(1'b1), 0, 1, 0);
        chk("wrap_old_phase_rejected", bus.acq_head_local, 0);
        run_entry(0, $urandom, $urandom, mk_dw3(1'b0), 0, 1, 0);
        chk("wrap_new_phase_head", bus.acq_head_local, 1);

        // starve mid-entry
        a0 = $urandom; a2 = $urandom; a3 = mk_dw3(exp_ph[0]);
        bus.is_io_queue = 0;
        push(a0); push($urandom);
        repeat (1000) tick();
        chk("starve_early", bus.cq_timeout, 0);
        repeat (100) tick();
        chk("starve_timeout", bus.cq_timeout, TO_EN);
        chk("starve_valid", bus.cqe_valid, 0);
        chk_queues("starve");
        if (TO_EN) begin
            run_entry(0, a0, a2, a3, 0, 1, 0);
        end else begin
            push(a2); push(a3);
            run_entry(0, a0, a2, a3, 0, 0, 0);
        end
        chk("timeout_sticky", bus.cq_timeout, TO_EN);

        // long ack hold with a second entry already queued
        a0 = $urandom; a2 = $urandom; a3 = mk_dw3(exp_ph[1]);
        b0 = $urandom; b2 = $urandom; b3 = mk_dw3(exp_ph[0]);
        push(a0); push($urandom); push(a2); push(a3);
        push(b0); push($urandom); push(b2); push(b3);
        run_entry(1, a0, a2, a3, 20, 0, 0);
        run_entry(0, b0, b2, b3, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            io = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) ack_done(1'($urandom_range(0, 1)));
            run_entry(io, $urandom, $urandom,
                      mk_dw3(($urandom_range(0, 4) == 0) ? ~exp_ph[io] : exp_ph[io]),
                      $urandom_range(0, 3), 1, 0);
        end

        // reset in the middle of an entry
        bus.is_io_queue = 1;
        push($urandom); push($urandom);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk("mid_rst_valid", bus.cqe_valid, 0);
        chk("mid_rst_timeout", bus.cq_timeout, 0);
        chk_queues("mid_rst");
        run_entry(1, $urandom, $urandom, mk_dw3(1'b1), 0, 1, 0);
        chk("post_rst_io_cnt", bus.io_cpl_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end
endmodule
